async_fifo_wr_arbiter: RTL and testbench
========================================

Name: async_fifo_wr_arbiter

Overview:
- Write-side arbiter that shares the single push port of async_fifo_top among NREQ requesters, all in the wclk domain.
- Grants one requester at a time in round-robin order and streams that requester's words as a burst.
- A burst ends on a last-word marker, on a beat limit, or when the owner drops its request.
- Honours the FIFO full flag, so no word is ever pushed into a full FIFO and no accepted word is lost.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 8, data width; matches the FIFO data width.
- MAXBURST, 16, maximum words accepted per grant; equals the FIFO depth by default.
- CNTW, 5, beat-counter width; must satisfy 2^CNTW > MAXBURST.

Ports:
- wclk  in  1  write clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; held high while a word is presented.
- req_data  in  NREQ*DWIDTH  word of requester i at bits [i*DWIDTH +: DWIDTH].
- req_last  in  NREQ  marks the presented word as the last of its burst.
- ack  out  NREQ  one-hot, combinational; the presented word of that requester is accepted this cycle.
- push  out  1  FIFO push, combinational.
- wdata  out  DWIDTH  FIFO write data, combinational mux of the owner's req_data.
- full  in  1  FIFO full flag, wclk domain.
- owner  out  clog2(NREQ)  index of the current grant holder; registered.
- busy  out  1  high in BURST state; registered.

Behaviour:
- Reset values: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, busy=0. Combinational outputs follow: push=0, ack=0, wdata=req_data slice 0.
- State machine: IDLE and BURST.
- IDLE:
  - If any req bit is set, select the first set bit scanning upward from rr_ptr and wrapping modulo NREQ.
  - Load owner, clear beat_cnt, go to BURST next edge.
  - Arbitration costs one cycle: push is never asserted in IDLE.
  - No request: stay in IDLE.
- BURST accept condition: accept = req[owner] & ~full.
  - push = accept; ack[owner] = accept; all other ack bits 0; wdata = owner's slice whenever busy.
  - On accept: beat_cnt increments.
- Burst termination, evaluated at the clock edge; on termination go to IDLE and set rr_ptr = (owner+1) mod NREQ.
  - (a) accept & req_last[owner].
  - (b) accept & beat_cnt == MAXBURST-1, i.e. the MAXBURST-th word.
  - (c) ~req[owner]: owner abandoned the burst, no push that cycle.
- full high in BURST: stall. push=0, ack=0, beat_cnt holds, owner holds. Stalled cycles do not count toward MAXBURST. Requester must hold req/req_data/req_last stable until ack.
- Throughput: one word per cycle during a burst. Re-arbitration gap is exactly one IDLE cycle between bursts.
- Fairness: after any burst end the previous owner has lowest priority. With all NREQ requesting continuously, grants cycle 0,1,2,3,0,...
- Requests from non-owners during BURST are ignored; they are seen at the next IDLE.
- req_last with a non-accepted word (full=1) has no effect until accepted.
- Reset asserted mid-burst: immediate return to reset values, push drops asynchronously via state. The word not yet acked is not pushed; the requester must re-present it after reset.
- full is used as-is. Its assertion latency is already conservative inside the FIFO, so the arbiter adds no margin.

Test Plan:
- Single requester: reset, then req[2]=1 with data 0x01..0x05 and req_last on 0x05, full=0. Required: owner=2, busy=1 one cycle after req. Five consecutive push pulses with wdata 01..05 and ack=4'b0100. Then busy=0; reader pops 01..05 in order.
- Round-robin: req=4'b1111 held, each burst 2 words with last. Required grant order 0,1,2,3,0; exactly one idle cycle between bursts; ack one-hot throughout.
- Beat limit: req[1] held with 20 words, no last, MAXBURST=16. Required: 16 pushes, busy drops, then a new grant. Requester 1 wins again only if it is the sole requester; the 17th word is acked in the second burst.
- Full stall: force full=1 for 5 cycles after the 3rd word of a burst. Required: push=0 and ack=0 during the stall, beat_cnt frozen at 3. Resume with the 4th word unchanged; no duplicates or drops vs a scoreboard.
- Abandon and reset: owner 3 drops req after 2 words. Required: return to IDLE, rr_ptr=0. Next, reset pulsed mid-burst at word 4. Required: busy=0, owner=0, push=0 immediately; nothing pushed until a fresh request is arbitrated after reset deasserts.

Source files
------------

// File: rtl/async_fifo_wr_arbiter_if.sv
// async_fifo_wr_arbiter_if: requester/FIFO-push bundle shared by the write-side arbiter
// slave  (arbiter): in req/req_data/req_last/full, out ack/push/wdata/owner/busy
// master (driver):  the mirror of slave
interface async_fifo_wr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 8
);
  localparam int OW = $clog2(NREQ);
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        ack;
  logic                   push;
  logic [DWIDTH-1:0]      wdata;
  logic                   full;
  logic [OW-1:0]          owner;
  logic                   busy;
  modport slave (
    input  req, req_data, req_last, full,
    output ack, push, wdata, owner, busy
  );
  modport master (
    output req, req_data, req_last, full,
    input  ack, push, wdata, owner, busy
  );
endinterface

// File: rtl/async_fifo_wr_arbiter.sv
// async_fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO push port among NREQ requesters
// wclk/reset: write clock, async active-high reset
// bus: requester handshake (req/req_data/req_last -> ack), FIFO push (push/wdata, full), status (owner/busy)
module async_fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DWIDTH   = 8,
  parameter int MAXBURST = 16,
  parameter int CNTW     = 5
) (
  input logic                    wclk,
  input logic                    reset,
  async_fifo_wr_arbiter_if.slave bus
);
  localparam int OW = $clog2(NREQ);
  typedef enum logic {IDLE, BURST} state_t;
  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d, rr_ptr_q, rr_ptr_d, sel, idx;
  logic [CNTW-1:0] beat_q, beat_d;
  logic            acc, fin;
  // scan downward so the last hit is the first requester at or after rr_ptr
  always_comb begin
    sel = rr_ptr_q;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = OW'((int'(rr_ptr_q) + k) % NREQ);
      if (bus.req[idx]) sel = idx;
    end
  end
  assign acc = (state_q == BURST) && bus.req[owner_q] && !bus.full;
  assign fin = (state_q == BURST) && (!bus.req[owner_q] ||
               (acc && (bus.req_last[owner_q] || beat_q == CNTW'(MAXBURST - 1))));
  assign bus.push  = acc;
  assign bus.ack   = acc ? ({{(NREQ-1){1'b0}}, 1'b1} << owner_q) : '0;
  assign bus.wdata = bus.req_data[owner_q*DWIDTH +: DWIDTH];
  assign bus.owner = owner_q;
  assign bus.busy  = state_q == BURST;
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    if (state_q == IDLE) begin
      if (|bus.req) begin
        state_d = BURST;
        owner_d = sel;
        beat_d  = '0;
      end
    end else begin
      beat_d = acc ? beat_q + 1'b1 : beat_q;
      if (fin) begin
        state_d  = IDLE;
        rr_ptr_d = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end
  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
    end
  end
endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// tb_async_fifo_wr_arbiter: directed checks of grant order, bursts, stalls, abandon and async reset
module tb_async_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  async_fifo_wr_arbiter_if #(.NREQ(4), .DWIDTH(8)) bus ();
  async_fifo_wr_arbiter #(.NREQ(4), .DWIDTH(8), .MAXBURST(16), .CNTW(5)) dut (
    .wclk(clk), .reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.push) got_q.push_back(bus.wdata);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_push", 32'(bus.push), 0);
    chk("idle_ack", 32'(bus.ack), 0);
    step();
  endtask
  task automatic beat(input int r, input logic [7:0] d, input logic l);
    bus.req_data[r*8 +: 8] = d;
    bus.req_last[r] = l;
    @(negedge clk);
    chk("beat_owner", 32'(bus.owner), 32'(r));
    chk("beat_busy", 32'(bus.busy), 1);
    chk("beat_push", 32'(bus.push), 1);
    chk("beat_ack", 32'(bus.ack), 32'(1) << r);
    chk("beat_wdata", 32'(bus.wdata), 32'(d));
    exp_q.push_back(d);
    step();
  endtask
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_last = '0;
    bus.req_data = 32'h000000A5;
    bus.full = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_push", 32'(bus.push), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_wdata", 32'(bus.wdata), 32'hA5);
    step();
    rst = 1'b0;
    bus.req = 4'b0100;
    bus.req_data[16 +: 8] = 8'h01;
    idle();
    for (int w = 1; w <= 5; w++) beat(2, 8'(w), w == 5);
    bus.req = '0;
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus.req_data[r*8 +: 8] = 8'(16 * r);
      bus.req_last[r] = 1'b0;
    end
    bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      idle();
      beat(b % 4, 8'(16 * (b % 4) + 2 * b), 1'b0);
      beat(b % 4, 8'(16 * (b % 4) + 2 * b + 1), 1'b1);
    end
    bus.req = '0;
    bus.req_last = '0;
    idle();
    bus.req = 4'b0010;
    bus.req_data[8 +: 8] = 8'h40;
    idle();
    for (int n = 0; n < 20; n++) begin
      if (n == 16) idle();
      beat(1, 8'(8'h40 + n), n == 19);
    end
    bus.req = '0;
    bus.req_last = '0;
    idle();
    bus.req = 4'b1000;
    bus.req_data[24 +: 8] = 8'h60;
    idle();
    beat(3, 8'h60, 1'b0);
    beat(3, 8'h61, 1'b0);
    beat(3, 8'h62, 1'b0);
    bus.req_data[24 +: 8] = 8'h63;
    bus.full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_push", 32'(bus.push), 0);
      chk("stall_ack", 32'(bus.ack), 0);
      chk("stall_busy", 32'(bus.busy), 1);
      chk("stall_owner", 32'(bus.owner), 3);
      chk("stall_beat", 32'(dut.beat_q), 3);
      step();
    end
    bus.full = 1'b0;
    beat(3, 8'h63, 1'b0);
    beat(3, 8'h64, 1'b0);
    beat(3, 8'h65, 1'b1);
    bus.req = '0;
    bus.req_last = '0;
    idle();
    bus.req = 4'b1000;
    bus.req_data[24 +: 8] = 8'h70;
    idle();
    beat(3, 8'h70, 1'b0);
    beat(3, 8'h71, 1'b0);
    bus.req = '0;
    @(negedge clk);
    chk("abandon_push", 32'(bus.push), 0);
    chk("abandon_busy", 32'(bus.busy), 1);
    step();
    @(negedge clk);
    chk("abandon_idle", 32'(bus.busy), 0);
    chk("abandon_rr", 32'(dut.rr_ptr_q), 0);
    step();
    bus.req = 4'b1000;
    bus.req_data[24 +: 8] = 8'h80;
    idle();
    beat(3, 8'h80, 1'b0);
    beat(3, 8'h81, 1'b0);
    beat(3, 8'h82, 1'b0);
    bus.req_data[24 +: 8] = 8'h83;
    @(negedge clk);
    chk("prerst_push", 32'(bus.push), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_owner", 32'(bus.owner), 0);
    chk("midrst_push", 32'(bus.push), 0);
    chk("midrst_ack", 32'(bus.ack), 0);
    step();
    rst = 1'b0;
    idle();
    beat(3, 8'h83, 1'b1);
    bus.req = '0;
    bus.req_last = '0;
    idle();
    idle();
    chk("sb_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("sb_word", 32'(got_q[i]), 32'(exp_q[i]));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
